// File: rtl/sn76489_pkg.sv
// sn76489_pkg: register codes, bus-master state encoding and register-class helper for SN76489 initiators
package sn76489_pkg;
  localparam logic [2:0] REG_FREQ1      = 3'b000;
  localparam logic [2:0] REG_FREQ2      = 3'b010;
  localparam logic [2:0] REG_FREQ3      = 3'b001;
  localparam logic [2:0] REG_ATT1       = 3'b100;
  localparam logic [2:0] REG_ATT2       = 3'b110;
  localparam logic [2:0] REG_ATT3       = 3'b101;
  localparam logic [2:0] REG_ATT_NOISE  = 3'b111;
  localparam logic [2:0] REG_NOISE_CTRL = 3'b011;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;
  function automatic logic is_freq_reg(input logic [2:0] code);
    return !code[2] && code != REG_NOISE_CTRL;
  endfunction
endpackage

// File: rtl/sn76489_byte_encoder.sv
// sn76489_byte_encoder: maps a register write onto the PSG latch byte, optional data byte and two-byte flag
module sn76489_byte_encoder
  import sn76489_pkg::*;
(
  input  logic [2:0] code,
  input  logic [9:0] value,
  output logic [7:0] latch_byte,
  output logic [7:0] data_byte,
  output logic       two_byte
);
  logic [3:0] nibble;
  assign two_byte   = is_freq_reg(code);
  assign nibble     = two_byte ? value[9:6] : code == REG_NOISE_CTRL ? {value[1:0], value[2], 1'b0} : value[3:0];
  assign latch_byte = {nibble, code, 1'b1};
  assign data_byte  = {value[5:0], 2'b00};
endmodule

// File: rtl/sn76489_bus_master.sv
// sn76489_bus_master: turns register-write requests into nCE/nWE/ready byte handshakes on the PSG bus
// Optional stuck-ready abort enabled by defining SN76489_BUS_MASTER_TIMEOUT_EN.
module sn76489_bus_master
  import sn76489_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic [2:0] reqReg,
  input  logic [9:0] reqValue,
  output logic [7:0] d,
  output logic       nCE,
  output logic       nWE,
  input  logic       ready,
  output logic       busy,
  output logic       timeoutErr
);
  state_t     state, next_state;
  logic [7:0] latch_byte, data_byte, data_q;
  logic       two_byte, pending, abort;

  sn76489_byte_encoder u_enc (
    .code      (reqReg),
    .value     (reqValue),
    .latch_byte(latch_byte),
    .data_byte (data_byte),
    .two_byte  (two_byte)
  );

  assign reqReady = state == IDLE;
  assign busy     = state != IDLE;
  assign nCE      = !(state == SETUP || state == STROBE);
  assign nWE      = state != STROBE;

`ifdef SN76489_BUS_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign abort = state == STROBE && !ready && cnt == CW'(TIMEOUT_CYCLES - 1);
  // STROBE-cycle counter, zero outside STROBE so each strobe starts fresh; abort flagged during RELEASE
  always_ff @(posedge clock or negedge nReset)
    if (!nReset) begin
      cnt        <= '0;
      timeoutErr <= 1'b0;
    end else begin
      cnt        <= state == STROBE ? cnt + 1'b1 : '0;
      timeoutErr <= abort;
    end
`else
  assign abort      = 1'b0;
  assign timeoutErr = TIMEOUT_CYCLES < 0;
`endif

  // next-state: one SETUP, strobe until ready (or abort), one RELEASE, then second byte or idle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = reqValid ? SETUP : IDLE;
      SETUP:   next_state = STROBE;
      STROBE:  next_state = (ready || abort) ? RELEASE : STROBE;
      default: next_state = pending ? SETUP : IDLE;
    endcase
  end

  // state, bus byte and pending data byte; d only moves on entry to SETUP so it is stable while nCE is low
  always_ff @(posedge clock or negedge nReset)
    if (!nReset) begin
      state   <= IDLE;
      d       <= 8'h00;
      data_q  <= 8'h00;
      pending <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && reqValid) begin
        d       <= latch_byte;
        data_q  <= data_byte;
        pending <= two_byte;
      end else if (state == RELEASE && pending) begin
        d       <= data_q;
        pending <= 1'b0;
      end else if (abort) begin
        pending <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sn76489_bus_master.sv
// tb_sn76489_bus_master: directed checks of reset, byte encoding, handshake timing, back-to-back and stuck-ready behaviour
module tb_sn76489_bus_master;
  logic       clock = 0, nReset = 1, reqValid = 0, ready = 0;
  logic [2:0] reqReg = 0;
  logic [9:0] reqValue = 0;
  logic       reqReady, nCE, nWE, busy, timeoutErr;
  logic [7:0] d;
  int vectors = 0, miscompares = 0;
  int ready_k = 1, strobe_n = 0, strobe_total = 0, busy_cycles = 0, idle_cycles = 0;
  int terr_cycles = 0, d_glitches = 0, rdy_while_busy = 0;
  bit stuck = 0, ce_low_prev = 0;
  logic [7:0] d_prev = 0;
  logic [7:0] bytes[$];

  sn76489_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .nReset(nReset), .reqValid(reqValid), .reqReady(reqReady),
    .reqReg(reqReg), .reqValue(reqValue), .d(d), .nCE(nCE), .nWE(nWE),
    .ready(ready), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clock = ~clock;

  // PSG-side model: answers ready on the k-th strobe cycle, records absorbed bytes, watches bus stability
  always @(negedge clock) begin
    if (!nCE && ce_low_prev && d !== d_prev) d_glitches++;
    ce_low_prev = !nCE;
    d_prev = d;
    if (busy) busy_cycles++; else idle_cycles++;
    if (busy && reqReady) rdy_while_busy++;
    if (timeoutErr) terr_cycles++;
    if (!nWE) begin
      strobe_n++;
      strobe_total++;
      ready = !stuck && strobe_n >= ready_k;
      if (ready) bytes.push_back(d);
    end else begin
      strobe_n = 0;
      ready = 0;
    end
  end

  task automatic clear_stats();
    bytes.delete();
    strobe_total = 0; busy_cycles = 0; idle_cycles = 0; terr_cycles = 0; d_glitches = 0; rdy_while_busy = 0;
  endtask

  task automatic send(input logic [2:0] r, input logic [9:0] v);
    reqValid = 1; reqReg = r; reqValue = v;
    for (int i = 0; i < 200 && !reqReady; i++) begin @(posedge clock); #1; end
    @(posedge clock); #1;
    reqValid = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1; return; end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    #3 nReset = 0;
    #1;
    vectors++; if (nCE !== 1'b1) begin miscompares++; $display("FAIL reset_nce got=%b exp=1", nCE); end
    vectors++; if (nWE !== 1'b1) begin miscompares++; $display("FAIL reset_nwe got=%b exp=1", nWE); end
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_d got=%h exp=00", d); end
    vectors++; if (reqReady !== 1'b1) begin miscompares++; $display("FAIL reset_reqready got=%b exp=1", reqReady); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (timeoutErr !== 1'b0) begin miscompares++; $display("FAIL reset_terr got=%b exp=0", timeoutErr); end
    repeat (2) @(posedge clock);
    #1 nReset = 1;
    @(posedge clock); #1;
    vectors++; if (busy !== 1'b0 || nCE !== 1'b1) begin miscompares++; $display("FAIL post_reset_idle busy=%b nce=%b exp 0/1", busy, nCE); end
  endtask

  task automatic test_freq1();
    bit ok;
    clear_stats(); ready_k = 2;
    send(3'b000, 10'd330);
    vectors++; if (d !== 8'h51) begin miscompares++; $display("FAIL freq1_setup_d got=%h exp=51", d); end
    vectors++; if ({nCE, nWE} !== 2'b01) begin miscompares++; $display("FAIL freq1_setup_strobes got=%b exp=01", {nCE, nWE}); end
    vectors++; if (reqReady !== 1'b0) begin miscompares++; $display("FAIL freq1_setup_reqready got=%b exp=0", reqReady); end
    @(posedge clock); #1;
    vectors++; if ({nCE, nWE} !== 2'b00) begin miscompares++; $display("FAIL freq1_strobe got=%b exp=00", {nCE, nWE}); end
    wait_idle(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL freq1_timeout got=busy exp=idle"); end
    vectors++; if (bytes.size() !== 2) begin miscompares++; $display("FAIL freq1_count got=%0d exp=2", bytes.size()); end
    vectors++; if (bytes[0] !== 8'h51) begin miscompares++; $display("FAIL freq1_byte0 got=%h exp=51", bytes[0]); end
    vectors++; if (bytes[1] !== 8'h28) begin miscompares++; $display("FAIL freq1_byte1 got=%h exp=28", bytes[1]); end
    vectors++; if (busy_cycles !== 8) begin miscompares++; $display("FAIL freq1_busy_cycles got=%0d exp=8", busy_cycles); end
    vectors++; if (d !== 8'h28) begin miscompares++; $display("FAIL freq1_d_hold got=%h exp=28", d); end
  endtask

  task automatic test_att2();
    bit ok;
    clear_stats(); ready_k = 3;
    send(3'b110, 10'h005);
    wait_idle(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL att2_timeout got=busy exp=idle"); end
    vectors++; if (bytes.size() !== 1 || bytes[0] !== 8'h5D) begin miscompares++; $display("FAIL att2_byte got=%0d/%h exp=1/5d", bytes.size(), bytes[0]); end
    vectors++; if (busy_cycles !== 5) begin miscompares++; $display("FAIL att2_busy_cycles got=%0d exp=5", busy_cycles); end
    vectors++; if (rdy_while_busy !== 0) begin miscompares++; $display("FAIL att2_reqready_busy got=%0d exp=0", rdy_while_busy); end
    vectors++; if (reqReady !== 1'b1) begin miscompares++; $display("FAIL att2_reqready_after got=%b exp=1", reqReady); end
  endtask

  task automatic test_noise_ctrl();
    bit ok;
    clear_stats(); ready_k = 1;
    send(3'b011, 10'b101);
    wait_idle(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL noise_timeout got=busy exp=idle"); end
    vectors++; if (bytes.size() !== 1 || bytes[0] !== 8'h67) begin miscompares++; $display("FAIL noise_byte got=%0d/%h exp=1/67", bytes.size(), bytes[0]); end
    vectors++; if (busy_cycles !== 3 || strobe_total !== 1) begin miscompares++; $display("FAIL noise_min_strobe got=%0d/%0d exp=3/1", busy_cycles, strobe_total); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_stats(); ready_k = 1;
    reqValid = 1; reqReg = 3'b100; reqValue = 10'h00A;
    @(posedge clock); #1;
    reqReg = 3'b101; reqValue = 10'h00D;
    idle_cycles = 0;
    wait_idle(100, ok);
    @(posedge clock); #1;
    reqValid = 0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_accept got=%b exp=1", busy); end
    wait_idle(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout got=busy exp=idle"); end
    vectors++; if (idle_cycles !== 1) begin miscompares++; $display("FAIL b2b_idle_gap got=%0d exp=1", idle_cycles); end
    vectors++; if (bytes.size() !== 2 || bytes[0] !== 8'hA9 || bytes[1] !== 8'hDB) begin miscompares++; $display("FAIL b2b_bytes got=%0d/%h/%h exp=2/a9/db", bytes.size(), bytes[0], bytes[1]); end
    vectors++; if (d_glitches !== 0) begin miscompares++; $display("FAIL b2b_d_stable got=%0d exp=0", d_glitches); end
  endtask

  task automatic test_stuck_ready();
    bit ok;
    clear_stats(); stuck = 1;
    send(3'b001, 10'h3FF);
`ifdef SN76489_BUS_MASTER_TIMEOUT_EN
    wait_idle(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stuck_abort got=busy exp=idle"); end
    vectors++; if (strobe_total !== 8) begin miscompares++; $display("FAIL stuck_strobes got=%0d exp=8", strobe_total); end
    vectors++; if (terr_cycles !== 1) begin miscompares++; $display("FAIL stuck_terr got=%0d exp=1", terr_cycles); end
    vectors++; if (d !== 8'hF3) begin miscompares++; $display("FAIL stuck_no_second got=%h exp=f3", d); end
    vectors++; if (busy_cycles !== 10) begin miscompares++; $display("FAIL stuck_busy got=%0d exp=10", busy_cycles); end
`else
    repeat (100) @(posedge clock);
    #1;
    vectors++; if ({busy, nCE, nWE} !== 3'b100) begin miscompares++; $display("FAIL stuck_hold got=%b exp=100", {busy, nCE, nWE}); end
    vectors++; if (terr_cycles !== 0) begin miscompares++; $display("FAIL stuck_terr got=%0d exp=0", terr_cycles); end
    vectors++; if (d !== 8'hF3) begin miscompares++; $display("FAIL stuck_d got=%h exp=f3", d); end
    #2 nReset = 0;
    #1;
    vectors++; if ({busy, nCE, nWE, reqReady} !== 4'b0111) begin miscompares++; $display("FAIL midreset_release got=%b exp=0111", {busy, nCE, nWE, reqReady}); end
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL midreset_d got=%h exp=00", d); end
    @(posedge clock); #1 nReset = 1;
    @(posedge clock); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_no_pending got=%b exp=0", busy); end
`endif
    stuck = 0;
    clear_stats(); ready_k = 1;
    send(3'b100, 10'h003);
    wait_idle(100, ok);
    vectors++; if (!ok || bytes.size() !== 1 || bytes[0] !== 8'h39) begin miscompares++; $display("FAIL recover_byte got=%0d/%0d/%h exp=1/1/39", ok, bytes.size(), bytes[0]); end
  endtask

  initial begin
    test_reset();
    test_freq1();
    test_att2();
    test_noise_ctrl();
    test_back_to_back();
    test_stuck_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sn76489_bus_master.md
# sn76489_bus_master

Bus initiator driving the SN76489 PSG CPU-side byte interface (d/nCE/nWE/ready) from a simple register-write request port. Sits between the console I/O decoder (or a test sequencer) and `sn76489_cpu_interface`. Encodes each register write into latch/data bytes, runs the chip-enable/write-strobe handshake and waits on `ready`. Optionally aborts on a stuck `ready`.

## Interface
- `TIMEOUT_CYCLES`, default 64: max STROBE cycles before abort (used only with timeout feature).
- `clock`  in  1  system clock, all state on rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  write request present.
- `reqReady`  out  1  request accepted this cycle when `reqValid & reqReady`.
- `reqReg`  in  3  target register code (freq1 000, freq2 010, freq3 001, att1 100, att2 110, att3 101, attNoise 111, noiseCtrl 011).
- `reqValue`  in  10  value; freq uses [9:0], att uses [3:0], noiseCtrl uses [2:0] = {feedbackType, feed[1:0]}.
- `d`  out  8  PSG data bus.
- `nCE`  out  1  PSG chip enable, active-low.
- `nWE`  out  1  PSG write enable, active-low.
- `ready`  in  1  PSG ready, high when write absorbed.
- `busy`  out  1  high whenever state != IDLE.
- `timeoutErr`  out  1  one-cycle pulse on abort (tied 0 without timeout feature).

## Operation
- Request captured (reg, value) on accept; inputs ignored until return to IDLE.
- Latch byte: `{nibble, reqReg, 1'b1}`; nibble = value[9:6] for freq, value[3:0] for att, `{value[1:0], value[2], 1'b0}` for noiseCtrl.
- Data byte (freq registers only: reg[2]=0 and reg!=011): `{value[5:0], 2'b00}`.
- States: IDLE -> SETUP -> STROBE -> RELEASE -> (second byte pending ? SETUP : IDLE).
- IDLE: nCE=1, nWE=1, d holds last byte, reqReady=1.
- SETUP (1 cycle): d=current byte, nCE=0, nWE=1.
- STROBE: nCE=0, nWE=0, d stable; exit to RELEASE on first cycle `ready` sampled 1 (minimum 1 STROBE cycle; `ready` ignored outside STROBE).
- RELEASE (1 cycle): nCE=1, nWE=1, d stable.
- 10-bit freq write = two full SETUP/STROBE/RELEASE sequences, no IDLE between.
- d never changes while nCE=0.

## Timing
- Reset (async assert, sync release): state IDLE, d=8'h00, nCE=1, nWE=1, reqReady=1, busy=0, timeoutErr=0; counter cleared.
- Reset mid-transfer: bus released immediately, pending second byte discarded.
- Accept at edge N: SETUP in cycle N+1, STROBE from N+2.
- Single-byte write with ready after k STROBE cycles: busy for k+2 cycles; reqReady high again the cycle after RELEASE.
- Back-to-back: `reqValid` held high -> next request accepted in first IDLE cycle (one idle cycle between transfers).
- `ready` already high on first STROBE cycle: STROBE lasts exactly 1 cycle.

## Configuration
- `SN76489_BUS_MASTER_TIMEOUT_EN` defined: STROBE cycle counter (width $clog2(TIMEOUT_CYCLES+1)); at TIMEOUT_CYCLES STROBE cycles without `ready`, go to RELEASE, pulse `timeoutErr` for one cycle, drop any pending second byte, then IDLE. Counter resets on entry to STROBE.
- Undefined: no counter; STROBE waits for `ready` indefinitely; `timeoutErr` constant 0.

## Structure
- Shared package `sn76489_pkg`: 3-bit register-code constants, state enum (IDLE, SETUP, STROBE, RELEASE), helper `is_freq_reg`.
- Sub-module `sn76489_byte_encoder` (combinational): reg+value -> latch byte, data byte, two-byte flag. Reused by any future PSG initiator.

## Test plan
- Reset with bus idle -> nCE=1, nWE=1, d=00, reqReady=1, busy=0.
- freq1 (000) value 330 into `sn76489_cpu_interface` -> bytes 8'h51 then 8'h28 on d; slave freq1 reads 330; busy drops after second RELEASE.
- att2 (110) value 4'h5 -> single byte 8'h5D; slave att2 = 5; reqReady low throughout transfer.
- noiseCtrl (011) value {1, 2'b01} -> byte 8'h67; slave noiseFeedbackType=1, noiseFeed=01.
- Back-to-back att1 A then att3 D with reqValid held -> exactly one IDLE cycle between; d constant while nCE=0.
- With TIMEOUT_EN, TIMEOUT_CYCLES=8, ready stuck 0 on freq3 write -> 8 STROBE cycles, one-cycle timeoutErr, no second byte, IDLE; without macro, same stimulus -> STROBE held, timeoutErr never 1.
